// File: rtl/pipe_result_credit_buffer.sv
// rtl/pipe_result_credit_buffer.sv - credit-gated result buffer for a no-stall pipeline (optional PIPE_RESULT_BYPASS_EN)
//
// Grants issue credits to the pipeline input and captures every emerging
// result into a circular buffer that drains on a ready/valid handshake.
// With PIPE_RESULT_BYPASS_EN defined, an empty buffer forwards pipe_data
// to out_data in the same cycle.
module pipe_result_credit_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  issue_ready,
   input  logic                  issue_valid,
   input  logic                  pipe_valid,
   input  logic [DATA_WIDTH-1:0] pipe_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      credits,
   output logic [CNT_W-1:0]      occupancy,
   output logic [1:0]            err_sticky
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]  FULL_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]      credits_q, credits_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic                  ready_q;
   logic [1:0]            err_q, err_d;

   logic                  issue, pop, pop_buf, push_wr, drop;
   logic                  empty, full, bypass_hit;
   logic [CNT_W:0]        cred_sum;

   // Handshake decode, output mux and next-state for counters and flags
   always_comb begin
      issue = issue_valid & ready_q;
      empty = (occ_q == '0);
      full  = (occ_q == FULL_C);
`ifdef PIPE_RESULT_BYPASS_EN
      bypass_hit = empty & pipe_valid;
      out_valid  = ~empty | pipe_valid;
      out_data   = bypass_hit ? pipe_data : mem_q[rd_ptr_q];
`else
      bypass_hit = 1'b0;
      out_valid  = ~empty;
      out_data   = mem_q[rd_ptr_q];
`endif
      pop     = out_valid & out_ready;
      // Only a pop of a stored entry moves the read pointer
      pop_buf = pop & ~empty;
      // A full buffer still accepts a push when its head leaves this cycle
      push_wr = pipe_valid & ~(bypass_hit & out_ready) & (~full | pop_buf);
      drop    = pipe_valid & full & ~pop_buf;

      occ_d = occ_q;
      if (push_wr) occ_d = occ_d + ONE_C;
      if (pop_buf) occ_d = occ_d - ONE_C;

      // Credits never exceed DEPTH even if the pipeline produced an unrequested result
      cred_sum = {1'b0, credits_q} + {{CNT_W{1'b0}}, pop} - {{CNT_W{1'b0}}, issue};
      if (cred_sum > {1'b0, FULL_C}) begin
         credits_d = FULL_C;
      end else begin
         credits_d = cred_sum[CNT_W-1:0];
      end

      err_d = err_q | {drop, issue_valid & ~ready_q};
   end

   // Credit counter, issue_ready flag and sticky error bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits_q <= FULL_C;
         ready_q   <= 1'b0;
         err_q     <= 2'b00;
      end else begin
         credits_q <= credits_d;
         ready_q   <= (credits_d != '0);
         err_q     <= err_d;
      end
   end

   // Circular buffer storage, pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_wr) begin
            mem_q[wr_ptr_q] <= pipe_data;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop_buf) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         occ_q <= occ_d;
      end
   end

   assign issue_ready = ready_q;
   assign credits     = credits_q;
   assign occupancy   = occ_q;
   assign err_sticky  = err_q;

endmodule

// File: tb/tb_pipe_result_credit_buffer.sv
// tb/tb_pipe_result_credit_buffer.sv - scoreboard bench for pipe_result_credit_buffer
module tb_pipe_result_credit_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_ready, issue_valid;
   logic        pipe_valid;
   logic [31:0] pipe_data;
   logic        out_valid, out_ready;
   logic [31:0] out_data;
   logic [2:0]  credits, occupancy;
   logic [1:0]  err_sticky;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   bit          inv_en;

   // two-stage fixed-latency pipeline model plus a direct injection port
   logic [1:0]  pv_q;
   logic [31:0] pd_q[2];
   logic [31:0] issue_val;
   logic        inj_valid;
   logic [31:0] inj_data;

   always #5 clk = ~clk;

   assign pipe_valid = pv_q[1] | inj_valid;
   assign pipe_data  = inj_valid ? inj_data : pd_q[1];

   pipe_result_credit_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_ready(issue_ready), .issue_valid(issue_valid),
      .pipe_valid(pipe_valid), .pipe_data(pipe_data),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .credits(credits), .occupancy(occupancy), .err_sticky(err_sticky)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pv_q    <= 2'b00;
         pd_q[0] <= '0;
         pd_q[1] <= '0;
      end else begin
         pv_q    <= {pv_q[0], issue_valid & issue_ready};
         pd_q[1] <= pd_q[0];
         pd_q[0] <= issue_val;
         if (issue_valid && issue_ready) exp_q.push_back(issue_val);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: scoreboard pop on every accepted output, plus credit invariant
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got %0h expected nothing", out_data);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL sb_data: got %0h expected %0h", out_data, e);
               end
            end
         end
         if (inv_en) begin
            int sum;
            checks++;
            sum = int'(credits) + int'(occupancy) + int'(pv_q[0]) + int'(pv_q[1]);
            if (sum != 4) begin
               errors++;
               $display("FAIL invariant: got %0d expected 4", sum);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      inv_en = 0;
      rst_n  = 1'b0;
      #1;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      inv_en = 1;
   endtask

   logic [31:0] vals [4];
   int          cyc;

   initial begin
      rst_n = 1'b0; issue_valid = 1'b0; issue_val = '0;
      inj_valid = 1'b0; inj_data = '0; out_ready = 1'b0; inv_en = 0;
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

      // reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_credits", 32'(credits), 32'd4);
      chk("rst_occ", 32'(occupancy), 32'd0);
      chk("rst_issue_ready", 32'(issue_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_err", 32'(err_sticky), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rel_issue_ready", 32'(issue_ready), 32'd1);
      chk("rel_credits", 32'(credits), 32'd4);
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      inv_en = 1;

      // fill four entries with out_ready low
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1; issue_val = vals[i];
         step();
      end
      issue_valid = 1'b0;
      chk("fill_issue_ready", 32'(issue_ready), 32'd0);
      chk("fill_credits", 32'(credits), 32'd0);
      repeat (3) step();
      chk("fill_occ", 32'(occupancy), 32'd4);
      chk("fill_head", out_data, 32'h11);

      // issue without credit
      issue_valid = 1'b1;
      step();
      issue_valid = 1'b0;
      chk("nocredit_credits", 32'(credits), 32'd0);
      chk("nocredit_err", 32'(err_sticky), 32'd1);

      // push while full with simultaneous pop
      inv_en = 0;
      inj_valid = 1'b1; inj_data = 32'h55; out_ready = 1'b1;
      exp_q.push_back(32'h55);
      step();
      inj_valid = 1'b0; out_ready = 1'b0;
      chk("fullpop_occ", 32'(occupancy), 32'd4);
      chk("fullpop_err", 32'(err_sticky), 32'd1);
      chk("fullpop_head", out_data, 32'h22);
      chk("fullpop_credits", 32'(credits), 32'd1);

      // push while full, no pop: dropped
      inj_valid = 1'b1; inj_data = 32'h66;
      step();
      inj_valid = 1'b0;
      chk("drop_err", 32'(err_sticky), 32'd3);
      chk("drop_occ", 32'(occupancy), 32'd4);
      chk("drop_head_stable", out_data, 32'h22);

      // drain on consecutive cycles
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_valid", 32'(out_valid), 32'd1);
         step();
      end
      chk("drain_occ", 32'(occupancy), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_credits", 32'(credits), 32'd4);
      chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b0;

      do_reset();
      chk("rst2_err", 32'(err_sticky), 32'd0);

      // continuous stream of 20 results, pointers wrap five times
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("stream_issue_ready", 32'(issue_ready), 32'd1);
         issue_valid = 1'b1; issue_val = 32'(i);
         step();
      end
      issue_valid = 1'b0;
      cyc = 0;
      while ((exp_q.size() != 0 || occupancy != 0) && cyc < 50) begin
         step();
         cyc++;
      end
      chk("stream_drain_timeout", 32'(cyc < 50), 32'd1);
      chk("stream_err", 32'(err_sticky), 32'd0);
      chk("stream_credits", 32'(credits), 32'd4);
      out_ready = 1'b0;

      // reset in the middle with occupancy three
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1; issue_val = 32'hA0 + 32'(i);
         step();
      end
      issue_valid = 1'b0;
      repeat (3) step();
      issue_valid = 1'b1;
      step();
      issue_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("mid_occ", 32'(occupancy), 32'd3);
      chk("mid_err", 32'(err_sticky), 32'd1);
      #2;
      inv_en = 0;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_credits", 32'(credits), 32'd4);
      chk("async_occ", 32'(occupancy), 32'd0);
      chk("async_err", 32'(err_sticky), 32'd0);
      chk("async_issue_ready", 32'(issue_ready), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      inv_en = 1;

      // empty-buffer result with out_ready high
      inv_en = 0;
      out_ready = 1'b1;
      inj_valid = 1'b1; inj_data = 32'hA5;
      exp_q.push_back(32'hA5);
      #1;
`ifdef PIPE_RESULT_BYPASS_EN
      chk("byp_out_valid", 32'(out_valid), 32'd1);
      chk("byp_out_data", out_data, 32'hA5);
      step();
      inj_valid = 1'b0;
      chk("byp_occ", 32'(occupancy), 32'd0);
      chk("byp_credits", 32'(credits), 32'd4);
`else
      chk("nobyp_out_valid", 32'(out_valid), 32'd0);
      step();
      inj_valid = 1'b0;
      chk("nobyp_next_valid", 32'(out_valid), 32'd1);
      chk("nobyp_next_data", out_data, 32'hA5);
      chk("nobyp_occ1", 32'(occupancy), 32'd1);
      step();
      chk("nobyp_occ0", 32'(occupancy), 32'd0);
      chk("nobyp_credits", 32'(credits), 32'd4);
`endif
      out_ready = 1'b0;
      step();
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
